// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux_n block.
// Optional per-channel statistics: STREAM_DEMUX_STATS_EN.
package stream_demux_pkg;

  localparam int STAT_CNT_W = 16;
  localparam logic [STAT_CNT_W-1:0] STAT_CNT_MAX = '1;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/stream_demux_chan.sv
// One output channel: single-entry holding register with valid/ready.
// STREAM_DEMUX_STATS_EN adds a saturating handshake counter.
module stream_demux_chan
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WIDTH-1:0]      data_o,
  output logic [STAT_CNT_W-1:0] cnt_o
);

  chan_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  assign drain   = (state_q == CH_FULL) && ready_i;
  assign valid_o = (state_q == CH_FULL);
  assign data_o  = data_q;

  // A load wins over a drain, so a same-cycle refill stays FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = CH_FULL;
      data_d  = data_i;
    end else if (drain) begin
      state_d = CH_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

`ifdef STREAM_DEMUX_STATS_EN
  logic [STAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drain && (cnt_q != STAT_CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/stream_demux_n.sv
// 1:N valid/ready stream demux with a registered buffer per channel.
// Define STREAM_DEMUX_STATS_EN to enable per-channel transfer counters.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [SEL_W-1:0]               in_sel,
  output logic [CHANNELS-1:0]            out_valid,
  input  logic [CHANNELS-1:0]            out_ready,
  output logic [CHANNELS*WIDTH-1:0]      out_data,
  output logic                           err_sel,
  output logic [CHANNELS*STAT_CNT_W-1:0] stat_cnt
);

  localparam int NSEL = 2 ** SEL_W;
  localparam logic [SEL_W:0] CH_LIM = CHANNELS[SEL_W:0];

  logic                sel_ok;
  logic                accept;
  logic [NSEL-1:0]     full_ext;
  logic [NSEL-1:0]     rdy_ext;
  logic [CHANNELS-1:0] load;
  logic                err_q, err_d;

  assign sel_ok = ({1'b0, in_sel} < CH_LIM);
  assign accept = in_valid && in_ready;

  // Padded to the full select range so an illegal select never
  // indexes past the channel vector.
  always_comb begin
    full_ext = '0;
    rdy_ext  = '0;
    full_ext[CHANNELS-1:0] = out_valid;
    rdy_ext[CHANNELS-1:0]  = out_ready;
    in_ready = 1'b1;
    if (sel_ok) begin
      in_ready = !full_ext[in_sel] || rdy_ext[in_sel];
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign load[k] = accept && sel_ok && (in_sel == SEL_W'(k));

    stream_demux_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[k]),
      .data_i (in_data),
      .valid_o(out_valid[k]),
      .ready_i(out_ready[k]),
      .data_o (out_data[k*WIDTH +: WIDTH]),
      .cnt_o  (stat_cnt[k*STAT_CNT_W +: STAT_CNT_W])
    );
  end

  assign err_d = accept && !sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sel = err_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboard bench for stream_demux_n (4-channel and 3-channel builds).
// Counter expectations follow STREAM_DEMUX_STATS_EN when defined.
module tb_stream_demux_n;

`ifdef STREAM_DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [7:0]  a_in_data = '0;
  logic [1:0]  a_in_sel = '0;
  logic [3:0]  a_out_valid;
  logic [3:0]  a_out_ready = '0;
  logic [31:0] a_out_data;
  logic        a_err;
  logic [63:0] a_stat;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_data = '0;
  logic [1:0]  b_in_sel = '0;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready = '0;
  logic [23:0] b_out_data;
  logic        b_err;
  logic [47:0] b_stat;

  stream_demux_n #(.WIDTH(8), .CHANNELS(4)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_data  (a_in_data),
    .in_sel   (a_in_sel),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_data (a_out_data),
    .err_sel  (a_err),
    .stat_cnt (a_stat)
  );

  stream_demux_n #(.WIDTH(8), .CHANNELS(3)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .in_sel   (b_in_sel),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_data (b_out_data),
    .err_sel  (b_err),
    .stat_cnt (b_stat)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0] expq [4][$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: drains, latency, hold-stability and err_sel on channel A.
  bit         lat_pend = 1'b0;
  logic [1:0] lat_sel;
  logic [7:0] lat_data;
  bit         stall_p [4];
  logic [7:0] stall_d [4];

  always @(negedge clk) begin
    if (!rst_n) begin
      lat_pend = 1'b0;
      for (int k = 0; k < 4; k++) stall_p[k] = 1'b0;
    end else begin
      if (lat_pend) begin
        chk("latency_valid", a_out_valid[lat_sel], 1);
        chk("latency_data", a_out_data[lat_sel*8 +: 8], lat_data);
      end
      chk("a_err_idle", a_err, 0);
      for (int k = 0; k < 4; k++) begin
        if (stall_p[k]) begin
          chk("hold_valid", a_out_valid[k], 1);
          chk("hold_data", a_out_data[k*8 +: 8], stall_d[k]);
        end
        if (a_out_valid[k] && a_out_ready[k]) begin
          chk("beat_expected", expq[k].size() != 0, 1);
          if (expq[k].size() != 0)
            chk("drain_data", a_out_data[k*8 +: 8], expq[k].pop_front());
        end
        stall_p[k] = a_out_valid[k] && !a_out_ready[k];
        stall_d[k] = a_out_data[k*8 +: 8];
      end
      lat_pend = a_in_valid && a_in_ready;
      lat_sel  = a_in_sel;
      lat_data = a_in_data;
    end
  end

  task automatic a_send(input logic [1:0] s, input logic [7:0] d);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_sel   = s;
    a_in_data  = d;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_ready", a_in_ready, 1);
    if (a_in_ready) expq[s].push_back(d);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_err", a_err, 0);
    chk("rst_stat", a_stat, 0);
    chk("rst_b_valid", b_out_valid, 0);
    for (int k = 0; k < 4; k++) expq[k].delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("init_out_valid", a_out_valid, 0);
    chk("init_out_data", a_out_data, 0);
    chk("init_err", a_err, 0);
    chk("init_stat", a_stat, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: one beat per channel, back-to-back
    a_out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_sel   = 2'(i);
      a_in_data  = 8'hA0 + 8'(i);
      @(negedge clk);
      chk("t1_in_ready", a_in_ready, 1);
      expq[i].push_back(8'hA0 + 8'(i));
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_stat", a_stat, STATS ? {4{16'd1}} : 64'd0);

    // 2: back-pressure on channel 2, then drain+fill in one cycle
    a_out_ready = 4'b1011;
    a_send(2'd2, 8'h55);
    a_in_valid = 1'b1;
    a_in_sel   = 2'd2;
    a_in_data  = 8'h66;
    repeat (3) begin
      @(negedge clk);
      chk("t2_in_ready_low", a_in_ready, 0);
      chk("t2_hold_55", a_out_data[23:16], 8'h55);
    end
    @(posedge clk); #1;
    a_out_ready[2] = 1'b1;
    @(negedge clk);
    chk("t2_in_ready_high", a_in_ready, 1);
    expq[2].push_back(8'h66);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("t2_no_bubble_v", a_out_valid[2], 1);
    chk("t2_no_bubble_d", a_out_data[23:16], 8'h66);
    @(posedge clk); #1;

    // 3: channel 1 stalled while channel 3 streams
    a_out_ready = 4'b1101;
    a_send(2'd1, 8'h11);
    a_send(2'd3, 8'h31);
    a_send(2'd3, 8'h32);
    a_send(2'd3, 8'h33);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_ch1_valid", a_out_valid[1], 1);
    chk("t3_ch1_data", a_out_data[15:8], 8'h11);
    chk("t3_ch3_empty", a_out_valid[3], 0);
    a_out_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("t3_all_empty", a_out_valid, 0);

    // 4: illegal select on the 3-channel build
    b_out_ready = 3'b111;
    b_in_valid  = 1'b1;
    b_in_sel    = 2'd3;
    b_in_data   = 8'hFF;
    @(negedge clk);
    chk("t4_ready_illegal", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_data = 8'h0E;
    @(negedge clk);
    chk("t4_err_pulse1", b_err, 1);
    chk("t4_valid_none1", b_out_valid, 0);
    chk("t4_ready_illegal2", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("t4_err_pulse2", b_err, 1);
    chk("t4_valid_none2", b_out_valid, 0);
    @(posedge clk); #1;
    b_in_valid = 1'b1;
    b_in_sel   = 2'd2;
    b_in_data  = 8'h77;
    @(negedge clk);
    chk("t4_err_clear", b_err, 0);
    chk("t4_ready_legal", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("t4_legal_valid", b_out_valid, 3'b100);
    chk("t4_legal_data", b_out_data[23:16], 8'h77);
    chk("t4_legal_noerr", b_err, 0);
    @(posedge clk); #1;

    // 5: reset in the middle of a stall
    a_out_ready = 4'b0000;
    a_send(2'd0, 8'hC0);
    a_send(2'd2, 8'hC2);
    @(posedge clk); #1;
    chk("t5_filled", a_out_valid, 4'b0101);
    do_reset();
    a_out_ready = 4'b1111;
    a_send(2'd1, 8'h5A);
    repeat (2) @(posedge clk);
    #1;

    // 6: counter saturation on channel 0
    do_reset();
    a_out_ready = 4'b1111;
    for (int i = 0; i < 70000; i++) a_send(2'd0, 8'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("t6_cnt0", a_stat[15:0], STATS ? 16'hFFFF : 16'h0);
    chk("t6_cnt_rest", a_stat[63:16], 0);

    for (int k = 0; k < 4; k++) chk("queue_empty", expq[k].size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
